// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the arbiter and the SPI memory controller.
// master = arbiter side, slave = requesters plus memory controller side.
interface mem_bus_arbiter_if;
    logic        c_req;
    logic        c_read;
    logic        c_write;
    logic [15:0] c_addr;
    logic [7:0]  c_wdata;
    logic [7:0]  c_rdata;
    logic        c_ready;

    logic        l_req;
    logic        l_read;
    logic        l_write;
    logic [15:0] l_addr;
    logic [7:0]  l_wdata;
    logic [7:0]  l_rdata;
    logic        l_ready;

    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_read;
    logic        mem_write;
    logic        mem_req;
    logic [7:0]  mem_data_in;
    logic        mem_ready;

    logic        owner;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  c_req, c_read, c_write, c_addr, c_wdata,
        input  l_req, l_read, l_write, l_addr, l_wdata,
        input  mem_data_in, mem_ready,
        output c_rdata, c_ready, l_rdata, l_ready,
        output mem_addr, mem_data_out, mem_read, mem_write, mem_req,
        output owner, busy, timeout_err
    );

    modport slave (
        output c_req, c_read, c_write, c_addr, c_wdata,
        output l_req, l_read, l_write, l_addr, l_wdata,
        output mem_data_in, mem_ready,
        input  c_rdata, c_ready, l_rdata, l_ready,
        input  mem_addr, mem_data_out, mem_read, mem_write, mem_req,
        input  owner, busy, timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / loader) arbiter in front of the SPI memory controller, with a
// BUSY watchdog. Every output is registered.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration and grant happen here
//   BUSY  | memory access outstanding, waiting for mem_ready or watchdog expiry
//   DONE  | one-cycle ready pulse to the owning port
module mem_bus_arbiter #(
    parameter int         ARB_MODE       = 1,
    parameter int         TIMEOUT_CYCLES = 1023,
    parameter logic [7:0] ABORT_DATA     = 8'hFF
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] watchdog, watchdog_nxt;
    logic            last_grant, last_grant_nxt;
    logic            owner_q, owner_nxt;
    logic            busy_q, busy_nxt;
    logic            timeout_err_q, timeout_err_nxt;
    logic            mem_req_q, mem_req_nxt;
    logic            mem_read_q, mem_read_nxt;
    logic            mem_write_q, mem_write_nxt;
    logic [15:0]     mem_addr_q, mem_addr_nxt;
    logic [7:0]      mem_data_out_q, mem_data_out_nxt;
    logic [7:0]      c_rdata_q, c_rdata_nxt;
    logic [7:0]      l_rdata_q, l_rdata_nxt;
    logic            c_ready_q, c_ready_nxt;
    logic            l_ready_q, l_ready_nxt;

    logic            pick_l;
    logic            sel_read;
    logic            sel_write;
    logic [15:0]     sel_addr;
    logic [7:0]      sel_wdata;

    // Round-robin: on a tie the port that did not win last time goes first.
    always_comb begin
        pick_l = bus.l_req;
        if (bus.c_req && bus.l_req) begin
            pick_l = (ARB_MODE == 0) ? 1'b1 : ~last_grant;
        end
        sel_read  = pick_l ? bus.l_read  : bus.c_read;
        sel_write = pick_l ? bus.l_write : bus.c_write;
        sel_addr  = pick_l ? bus.l_addr  : bus.c_addr;
        sel_wdata = pick_l ? bus.l_wdata : bus.c_wdata;
    end

    always_comb begin
        state_nxt        = state;
        watchdog_nxt     = watchdog;
        last_grant_nxt   = last_grant;
        owner_nxt        = owner_q;
        timeout_err_nxt  = timeout_err_q;
        mem_req_nxt      = mem_req_q;
        mem_read_nxt     = mem_read_q;
        mem_write_nxt    = mem_write_q;
        mem_addr_nxt     = mem_addr_q;
        mem_data_out_nxt = mem_data_out_q;
        c_rdata_nxt      = c_rdata_q;
        l_rdata_nxt      = l_rdata_q;
        c_ready_nxt      = 1'b0;
        l_ready_nxt      = 1'b0;
        busy_nxt         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    owner_nxt        = pick_l;
                    last_grant_nxt   = pick_l;
                    mem_addr_nxt     = sel_addr;
                    mem_data_out_nxt = sel_wdata;
                    watchdog_nxt     = '0;
                    if (sel_write) begin
                        mem_req_nxt   = 1'b1;
                        mem_write_nxt = 1'b1;
                        mem_read_nxt  = 1'b0;
                        state_nxt     = BUSY;
                    end else if (sel_read) begin
                        mem_req_nxt   = 1'b1;
                        mem_write_nxt = 1'b0;
                        mem_read_nxt  = 1'b1;
                        state_nxt     = BUSY;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready || watchdog == WD_LAST) begin
                    mem_req_nxt   = 1'b0;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    state_nxt     = DONE;
                    if (!bus.mem_ready) begin
                        timeout_err_nxt = 1'b1;
                    end
                    if (mem_read_q) begin
                        if (owner_q) begin
                            l_rdata_nxt = bus.mem_ready ? bus.mem_data_in : ABORT_DATA;
                        end else begin
                            c_rdata_nxt = bus.mem_ready ? bus.mem_data_in : ABORT_DATA;
                        end
                    end
                end else begin
                    watchdog_nxt = watchdog + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == DONE) begin
            c_ready_nxt = ~owner_nxt;
            l_ready_nxt = owner_nxt;
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            watchdog       <= '0;
            last_grant     <= 1'b0;
            owner_q        <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            c_rdata_q      <= '0;
            l_rdata_q      <= '0;
            c_ready_q      <= 1'b0;
            l_ready_q      <= 1'b0;
        end else begin
            state          <= state_nxt;
            watchdog       <= watchdog_nxt;
            last_grant     <= last_grant_nxt;
            owner_q        <= owner_nxt;
            busy_q         <= busy_nxt;
            timeout_err_q  <= timeout_err_nxt;
            mem_req_q      <= mem_req_nxt;
            mem_read_q     <= mem_read_nxt;
            mem_write_q    <= mem_write_nxt;
            mem_addr_q     <= mem_addr_nxt;
            mem_data_out_q <= mem_data_out_nxt;
            c_rdata_q      <= c_rdata_nxt;
            l_rdata_q      <= l_rdata_nxt;
            c_ready_q      <= c_ready_nxt;
            l_ready_q      <= l_ready_nxt;
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_out = mem_data_out_q;
    assign bus.c_rdata      = c_rdata_q;
    assign bus.l_rdata      = l_rdata_q;
    assign bus.c_ready      = c_ready_q;
    assign bus.l_ready      = l_ready_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share one
// set of stimulus; `mode` picks which instance is active and observed.
module tb_mem_bus_arbiter;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset;
    logic mode;
    always #5 clk = ~clk;

    logic        c_req, c_read, c_write, l_req, l_read, l_write, mem_ready;
    logic [15:0] c_addr, l_addr;
    logic [7:0]  c_wdata, l_wdata, mem_data_in;

    logic [7:0]  c_rdata, l_rdata, mem_data_out;
    logic [15:0] mem_addr;
    logic        c_ready, l_ready, mem_read, mem_write, mem_req, owner, busy, timeout_err;
    logic [47:0] obs_v [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter_if bus ();
        assign bus.c_req       = c_req & (mode == 1'(g));
        assign bus.l_req       = l_req & (mode == 1'(g));
        assign bus.mem_ready   = mem_ready & (mode == 1'(g));
        assign bus.c_read      = c_read;
        assign bus.c_write     = c_write;
        assign bus.c_addr      = c_addr;
        assign bus.c_wdata     = c_wdata;
        assign bus.l_read      = l_read;
        assign bus.l_write     = l_write;
        assign bus.l_addr      = l_addr;
        assign bus.l_wdata     = l_wdata;
        assign bus.mem_data_in = mem_data_in;

        mem_bus_arbiter #(.ARB_MODE(g), .TIMEOUT_CYCLES(TMO), .ABORT_DATA(8'hFF)) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );

        assign obs_v[g] = {bus.c_rdata, bus.c_ready, bus.l_rdata, bus.l_ready, bus.mem_addr,
                           bus.mem_data_out, bus.mem_read, bus.mem_write, bus.mem_req,
                           bus.owner, bus.busy, bus.timeout_err};
    end

    assign {c_rdata, c_ready, l_rdata, l_ready, mem_addr, mem_data_out, mem_read, mem_write,
            mem_req, owner, busy, timeout_err} = obs_v[mode];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } op_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state, indexed [instance][port], port 0 = CPU, 1 = loader.
    bit         lg   [2];
    logic [7:0] mrd  [2][2];
    bit         mtmo [2];
    op_t        cur  [2];
    op_t        preset [2];
    bit         use_preset [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk_op(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
        op_t o;
        o.rd = rd; o.wr = wr; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        int r;
        r = $urandom_range(0, 9);
        return mk_op(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, 16'($urandom), 8'($urandom));
    endfunction

    task automatic drive(input int p, input bit req);
        if (p == 0) begin
            c_req = req; c_read = cur[0].rd; c_write = cur[0].wr;
            c_addr = cur[0].addr; c_wdata = cur[0].wdata;
        end else begin
            l_req = req; l_read = cur[1].rd; l_write = cur[1].wr;
            l_addr = cur[1].addr; l_wdata = cur[1].wdata;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lg[i] = 1'b0; mtmo[i] = 1'b0; mrd[i][0] = 8'h00; mrd[i][1] = 8'h00;
        end
    endtask

    // Port p issues n[p] transactions back to back; the bench also plays the memory.
    task automatic episode(input int n_c, input int n_l, input bit no_resp,
                           input bit fixed, input int fixed_lat, input logic [7:0] fixed_data);
        int         left [2];
        bit         reraise [2];
        int         exp_own, gap, req_cnt, lat, budget, exp_cnt;
        bit         prev_busy, seen_grant, is_rd;
        logic [7:0] rsp;
        left[0] = n_c; left[1] = n_l;
        reraise[0] = 1'b0; reraise[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (left[p] > 0) begin
                cur[p] = use_preset[p] ? preset[p] : rand_op();
                use_preset[p] = 1'b0;
                drive(p, 1'b1);
            end
        end
        exp_own = 0; gap = 0; req_cnt = 0; lat = 0; budget = 0; rsp = 8'h00;
        prev_busy = busy; seen_grant = 1'b0; is_rd = 1'b0;
        while ((left[0] + left[1]) > 0 && budget < 400) begin
            @(posedge clk); #1;
            budget++;
            for (int p = 0; p < 2; p++) begin
                if (reraise[p]) begin
                    cur[p] = rand_op();
                    drive(p, 1'b1);
                    reraise[p] = 1'b0;
                end
            end
            if (busy && !prev_busy) begin
                if (left[0] > 0 && left[1] > 0)
                    exp_own = (mode == 1'b0) ? 1 : (lg[mode] ? 0 : 1);
                else
                    exp_own = (left[1] > 0) ? 1 : 0;
                check("owner", owner, exp_own);
                if (seen_grant) check("idle_gap", gap, 1);
                seen_grant = 1'b1;
                is_rd = cur[exp_own].rd && !cur[exp_own].wr;
                if (cur[exp_own].rd || cur[exp_own].wr) begin
                    check("mem_req", mem_req, 1);
                    check("mem_addr", mem_addr, cur[exp_own].addr);
                    check("mem_rw", {mem_read, mem_write}, {is_rd, cur[exp_own].wr});
                    if (cur[exp_own].wr) check("mem_data_out", mem_data_out, cur[exp_own].wdata);
                end else begin
                    check("noop_no_req", {mem_req, busy}, 2'b01);
                end
                req_cnt = 0;
                lat = fixed ? fixed_lat : $urandom_range(0, 5);
                rsp = fixed ? fixed_data : 8'($urandom);
                gap = 0;
            end
            if (!busy) gap++;

            mem_ready = 1'b0;
            mem_data_in = 8'($urandom);
            if (mem_req) begin
                if (!no_resp && req_cnt == lat) begin
                    mem_ready = 1'b1;
                    mem_data_in = rsp;
                end
                req_cnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end

            if (c_ready || l_ready) begin
                check("one_ready", {c_ready, l_ready}, (exp_own == 1) ? 2'b01 : 2'b10);
                check("ready_in_done", busy, 1);
                if (!(cur[exp_own].rd || cur[exp_own].wr)) exp_cnt = 0;
                else exp_cnt = no_resp ? TMO : lat + 1;
                check("busy_cycles", req_cnt, exp_cnt);
                if (is_rd) mrd[mode][exp_own] = no_resp ? 8'hFF : rsp;
                if (no_resp && (cur[exp_own].rd || cur[exp_own].wr)) mtmo[mode] = 1'b1;
                check("c_rdata", c_rdata, mrd[mode][0]);
                check("l_rdata", l_rdata, mrd[mode][1]);
                check("timeout_err", timeout_err, mtmo[mode]);
                lg[mode] = (exp_own == 1);
                left[exp_own]--;
                drive(exp_own, 1'b0);
                if (left[exp_own] > 0) reraise[exp_own] = 1'b1;
            end
            prev_busy = busy;
        end
        check("episode_done", left[0] + left[1], 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("ready_pulse_end", {c_ready, l_ready, busy}, 3'b000);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b1;
        c_req = 0; c_read = 0; c_write = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_read = 0; l_write = 0; l_addr = 0; l_wdata = 0;
        mem_ready = 0; mem_data_in = 0;
        use_preset[0] = 0; use_preset[1] = 0;
        cur[0] = mk_op(0, 0, 0, 0); cur[1] = mk_op(0, 0, 0, 0);
        model_reset();
        #12;
        check("reset_state_fp", obs_v[0], 48'h0);
        check("reset_state_rr", obs_v[1], 48'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU read, controller answers A5 after a few cycles
        preset[0] = mk_op(1, 0, 16'h1234, 8'h00); use_preset[0] = 1;
        episode(1, 0, 0, 1, 5, 8'hA5);

        // fixed priority: loader write beats CPU read
        mode = 1'b0;
        preset[1] = mk_op(0, 1, 16'h0100, 8'h3C); use_preset[1] = 1;
        preset[0] = mk_op(1, 0, 16'h0002, 8'h00); use_preset[0] = 1;
        episode(1, 1, 0, 1, 2, 8'h5E);

        // round-robin with both held: L, C, L, C
        mode = 1'b1;
        episode(2, 2, 0, 0, 0, 8'h00);

        // loader read that the controller never answers
        preset[1] = mk_op(1, 0, 16'h0BAD, 8'h00); use_preset[1] = 1;
        episode(0, 1, 1, 0, 0, 8'h00);
        episode(1, 1, 0, 0, 0, 8'h00);

        // read+write is a write; then a no-op request
        preset[0] = mk_op(1, 1, 16'h00FF, 8'h77); use_preset[0] = 1;
        episode(1, 0, 0, 0, 0, 8'h00);
        preset[0] = mk_op(0, 0, 16'h0042, 8'h11); use_preset[0] = 1;
        episode(1, 0, 0, 0, 0, 8'h00);

        // reset while a CPU write is outstanding
        cur[0] = mk_op(0, 1, 16'h4321, 8'h5A);
        drive(0, 1'b1);
        for (int i = 0; i < 10 && !mem_req; i++) begin
            @(posedge clk); #1;
        end
        check("rst_pre_busy", {mem_req, mem_write, busy}, 3'b111);
        #2 reset = 1'b1;
        #1 check("rst_mid_busy", {mem_req, mem_write, busy, c_ready, timeout_err}, 5'b0);
        drive(0, 1'b0);
        #3 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_no_ready", {c_ready, l_ready, busy}, 3'b000);
        end
        episode(1, 0, 0, 0, 0, 8'h00);

        for (int k = 0; k < 25; k++) begin
            int nc, nl;
            mode = 1'($urandom_range(0, 1));
            nc = $urandom_range(0, 3);
            nl = $urandom_range(0, 3);
            if (nc + nl == 0) nc = 1;
            episode(nc, nl, ($urandom_range(0, 7) == 0), 0, 0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
